// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide, one bit per
// cycle, with a zero-latency path for divide-by-zero and signed-overflow divides.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  kill,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] rs1_val,
  input  logic [DATA_WIDTH-1:0] rs2_val,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [ADDR_WIDTH-1:0] rd_out,
  output logic                  wb_en
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] MIN_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  state_t state, state_nxt;

  logic [2:0]              op;
  logic [ADDR_WIDTH-1:0]   rd_hold;
  logic                    sign_a, sign_b;
  logic [DATA_WIDTH-1:0]   oper;
  logic [2*DATA_WIDTH-1:0] acc;
  logic [CW-1:0]           counter;

  function automatic logic [DATA_WIDTH-1:0] cneg_w(input logic [DATA_WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*DATA_WIDTH-1:0] cneg_d(input logic [2*DATA_WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  logic                  is_div, sgn_a_en, sgn_b_en, div_zero, div_ovf, fast;
  logic [DATA_WIDTH-1:0] mag_a, mag_b, fast_val;

  always_comb begin
    is_div   = funct3[2];
    sgn_a_en = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
    sgn_b_en = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    mag_a    = cneg_w(rs1_val, sgn_a_en && rs1_val[DATA_WIDTH-1]);
    mag_b    = cneg_w(rs2_val, sgn_b_en && rs2_val[DATA_WIDTH-1]);
    div_zero = (rs2_val == '0);
    div_ovf  = !funct3[0] && (rs1_val == MIN_NEG) && (rs2_val == '1);
    fast     = is_div && (div_zero || div_ovf);
    if (div_zero) fast_val = funct3[1] ? rs1_val : '1;
    else          fast_val = funct3[1] ? '0 : MIN_NEG;
  end

  // acc holds {high partial product, multiplier} for multiply and {remainder, dividend/quotient}
  // for divide; oper is the multiplicand or divisor magnitude.
  logic [DATA_WIDTH:0]     mul_sum, div_trial;
  logic [2*DATA_WIDTH-1:0] acc_step, prod;
  logic [DATA_WIDTH-1:0]   quot, rem, fix_val;

  always_comb begin
    mul_sum   = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + (acc[0] ? {1'b0, oper} : '0);
    div_trial = {acc[2*DATA_WIDTH-1:DATA_WIDTH], acc[DATA_WIDTH-1]} - {1'b0, oper};
    if (!op[2])              acc_step = {mul_sum, acc[DATA_WIDTH-1:1]};
    else if (div_trial[DATA_WIDTH]) acc_step = {acc[2*DATA_WIDTH-2:0], 1'b0};
    else                     acc_step = {div_trial[DATA_WIDTH-1:0], acc[DATA_WIDTH-2:0], 1'b1};
    prod = cneg_d(acc, sign_a ^ sign_b);
    quot = cneg_w(acc[DATA_WIDTH-1:0], sign_a ^ sign_b);
    rem  = cneg_w(acc[2*DATA_WIDTH-1:DATA_WIDTH], sign_a);
    if (op[2]) fix_val = op[1] ? rem : quot;
    else       fix_val = (op[1:0] == 2'b00) ? prod[DATA_WIDTH-1:0] : prod[2*DATA_WIDTH-1:DATA_WIDTH];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = fast ? DONE : CALC;
      CALC: begin
        if (kill)                 state_nxt = IDLE;
        else if (counter == LAST) state_nxt = FIX;
      end
      FIX:     state_nxt = kill ? IDLE : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      result  <= '0;
      rd_out  <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        counter <= '0;
        if (fast) begin
          result <= fast_val;
          rd_out <= rd_addr;
        end
      end else if (state == CALC && !kill) begin
        counter <= counter + 1'b1;
      end else if (state == FIX && !kill) begin
        result <= fix_val;
        rd_out <= rd_hold;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      op      <= funct3;
      rd_hold <= rd_addr;
      sign_a  <= sgn_a_en && rs1_val[DATA_WIDTH-1];
      sign_b  <= sgn_b_en && rs2_val[DATA_WIDTH-1];
      oper    <= is_div ? mag_b : mag_a;
      acc     <= {{DATA_WIDTH{1'b0}}, (is_div ? mag_a : mag_b)};
    end else if (state == CALC) begin
      acc <= acc_step;
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign wb_en = done && (rd_out != '0);
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: expected results are queued at issue and popped on done.
module tb_muldiv_unit;
  localparam int W  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          kill = 1'b0;
  logic [2:0]    funct3 = '0;
  logic [W-1:0]  rs1_val = '0;
  logic [W-1:0]  rs2_val = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          busy, done, wb_en;
  logic [W-1:0]  result;
  logic [AW-1:0] rd_out;

  typedef struct {
    logic [W-1:0]  res;
    logic [AW-1:0] rd;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  localparam logic [2:0]   OP_F [7] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7};
  localparam logic [W-1:0] OP_A [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                                        32'hFFFFFFF9, 32'd100, 32'd100};
  localparam logic [W-1:0] OP_B [7] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2,
                                        32'd2, 32'd7, 32'd7};
  localparam logic [W-1:0] OP_E [7] = '{32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                                        32'hFFFFFFFF, 32'd14, 32'd2};
  localparam logic [2:0]   FP_F [3] = '{3'd5, 3'd6, 3'd4};
  localparam logic [W-1:0] FP_A [3] = '{32'd5, 32'd5, 32'h80000000};
  localparam logic [W-1:0] FP_B [3] = '{32'd0, 32'd0, 32'hFFFFFFFF};
  localparam logic [W-1:0] FP_E [3] = '{32'hFFFFFFFF, 32'd5, 32'h80000000};

  muldiv_unit #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kill(kill), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rd_addr(rd_addr),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out), .wb_en(wb_en)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [W-1:0] mn;
    mn = 32'h80000000;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    p  = '0;
    case (f)
      3'd0: p = ua * ub;
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return '1;
        if (a == mn && b == '1) return mn;
        p = sa / sb;
      end
      3'd5: begin
        if (b == 0) return '1;
        p = ua / ub;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == mn && b == '1) return '0;
        p = sa % sb;
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub;
      end
    endcase
    return p[31:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_start(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [AW-1:0] rd);
    funct3 = f; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
    tick();
    start = 1'b0;
    rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom_range(0, 7));
  endtask

  task automatic issue(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] rd, input logic [W-1:0] er);
    exp_t e;
    e.res = er;
    e.rd  = rd;
    exp_q.push_back(e);
    drive_start(f, a, b, rd);
  endtask

  task automatic wait_done(output int cyc, output int bcyc);
    cyc  = 0;
    bcyc = (busy === 1'b1) ? 1 : 0;
    while (done !== 1'b1 && cyc < 100) begin
      tick();
      cyc++;
      if (busy === 1'b1) bcyc++;
    end
  endtask

  function automatic exp_t pop_exp();
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin e.res = 'x; e.rd = 'x; end
    return e;
  endfunction

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_chk++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL reset_wb_en: got %b want 0", wb_en); end
    n_chk++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_chk++; if (rd_out !== '0) begin n_fail++; $display("FAIL reset_rd_out: got %h want 0", rd_out); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_mul();
    int cyc, bcyc;
    exp_t e;
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd1, 32'hFFFFFFEB);
    wait_done(cyc, bcyc);
    e = pop_exp();
    n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d edges want 33", cyc); end
    n_chk++; if (bcyc !== 34) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d want 34", bcyc); end
    n_chk++; if (result !== e.res) begin n_fail++; $display("FAIL mul_result: got %h want %h", result, e.res); end
    n_chk++; if (rd_out !== e.rd) begin n_fail++; $display("FAIL mul_rd_out: got %h want %h", rd_out, e.rd); end
    tick();
    n_chk++; if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL mul_done_pulse: done=%b busy=%b want 0/0", done, busy);
    end
  endtask

  task automatic test_ops();
    int cyc, bcyc;
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      issue(OP_F[i], OP_A[i], OP_B[i], 5'(i + 2), OP_E[i]);
      wait_done(cyc, bcyc);
      e = pop_exp();
      n_chk++; if (done !== 1'b1 || cyc !== 33) begin
        n_fail++; $display("FAIL op%0d_latency: done=%b after %0d edges want 1 after 33", i, done, cyc);
      end
      n_chk++; if (result !== e.res) begin
        n_fail++; $display("FAIL op%0d_result f=%0d: got %h want %h", i, OP_F[i], result, e.res);
      end
      tick();
    end
  endtask

  task automatic test_fast_path();
    int cyc, bcyc;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      issue(FP_F[i], FP_A[i], FP_B[i], 5'(i + 20), FP_E[i]);
      wait_done(cyc, bcyc);
      e = pop_exp();
      n_chk++; if (done !== 1'b1 || cyc !== 0) begin
        n_fail++; $display("FAIL fast%0d_latency: done=%b after %0d extra edges want 1 after 0", i, done, cyc);
      end
      n_chk++; if (result !== e.res || rd_out !== e.rd) begin
        n_fail++; $display("FAIL fast%0d_result: got %h rd %0d want %h rd %0d", i, result, rd_out, e.res, e.rd);
      end
      tick();
    end
  endtask

  task automatic test_rd_zero();
    int cyc, bcyc;
    exp_t e;
    issue(3'd0, 32'd3, 32'd4, 5'd0, 32'd12);
    wait_done(cyc, bcyc);
    e = pop_exp();
    n_chk++; if (done !== 1'b1 || result !== e.res) begin
      n_fail++; $display("FAIL rd0_result: done=%b result=%h want 1 %h", done, result, e.res);
    end
    n_chk++; if (wb_en !== 1'b0) begin n_fail++; $display("FAIL rd0_wb_en: got %b want 0", wb_en); end
    tick();
    issue(3'd0, 32'd3, 32'd4, 5'd10, 32'd12);
    wait_done(cyc, bcyc);
    e = pop_exp();
    n_chk++; if (wb_en !== 1'b1) begin n_fail++; $display("FAIL rd10_wb_en: got %b want 1", wb_en); end
    n_chk++; if (rd_out !== e.rd) begin n_fail++; $display("FAIL rd10_rd_out: got %0d want %0d", rd_out, e.rd); end
    tick();
  endtask

  task automatic test_kill();
    int seen;
    drive_start(3'd0, 32'd9, 32'd9, 5'd7);
    repeat (10) tick();
    kill = 1'b1;
    tick();
    kill = 1'b0;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL kill_idle: busy=%b done=%b want 0/0", busy, done);
    end
    n_chk++; if (result !== 32'd12) begin n_fail++; $display("FAIL kill_result_hold: got %h want 0000000c", result); end
    seen = 0;
    repeat (40) begin tick(); if (done === 1'b1) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL kill_no_done: %0d done cycles want 0", seen); end
  endtask

  task automatic test_start_while_busy();
    int cyc, bcyc;
    exp_t e;
    issue(3'd0, 32'd6, 32'd7, 5'd3, 32'd42);
    repeat (5) tick();
    drive_start(3'd5, 32'd9, 32'd0, 5'd4);
    wait_done(cyc, bcyc);
    e = pop_exp();
    n_chk++; if (result !== e.res || rd_out !== e.rd) begin
      n_fail++; $display("FAIL busy_start_result: got %h rd %0d want %h rd %0d", result, rd_out, e.res, e.rd);
    end
    drive_start(3'd5, 32'd9, 32'd0, 5'd4);
    n_chk++; if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL done_cycle_start: busy=%b done=%b want 0/0", busy, done);
    end
  endtask

  task automatic test_kill_start_idle();
    int cyc, bcyc;
    exp_t e;
    kill = 1'b1;
    issue(3'd5, 32'd5, 32'd0, 5'd4, 32'hFFFFFFFF);
    wait_done(cyc, bcyc);
    kill = 1'b0;
    e = pop_exp();
    n_chk++; if (done !== 1'b1 || cyc !== 0 || result !== e.res) begin
      n_fail++; $display("FAIL kill_start_idle: done=%b edges=%0d result=%h want 1 0 %h", done, cyc, result, e.res);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    exp_t e;
    logic [2:0] f;
    logic [W-1:0] a, b;
    logic [AW-1:0] rd;
    for (int i = 0; i < 24; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = (i % 6 == 0) ? '0 : (i % 6 == 1) ? W'($urandom_range(1, 15)) : $urandom;
      if (i % 8 == 3) begin a = 32'h80000000; b = '1; end
      rd = AW'($urandom_range(0, 31));
      issue(f, a, b, rd, model(f, a, b));
      wait_done(cyc, bcyc);
      e = pop_exp();
      n_chk++; if (done !== 1'b1 || result !== e.res || rd_out !== e.rd || wb_en !== (e.rd != 0)) begin
        n_fail++;
        $display("FAIL rand%0d f=%0d a=%h b=%h: done=%b result=%h rd=%0d wb=%b want %h rd=%0d",
                 i, f, a, b, done, result, rd_out, wb_en, e.res, e.rd);
      end
      tick();
    end
  endtask

  task automatic test_async_reset();
    int seen;
    drive_start(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd9);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || done !== 1'b0 || wb_en !== 1'b0) begin
      n_fail++; $display("FAIL async_rst_ctrl: busy=%b done=%b wb_en=%b want 0", busy, done, wb_en);
    end
    n_chk++; if (result !== '0 || rd_out !== '0) begin
      n_fail++; $display("FAIL async_rst_data: result=%h rd_out=%h want 0", result, rd_out);
    end
    #3 rst_n = 1'b1;
    seen = 0;
    repeat (40) begin tick(); if (done === 1'b1) seen++; end
    n_chk++; if (seen !== 0) begin n_fail++; $display("FAIL async_rst_no_done: %0d done cycles want 0", seen); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_ops();
    test_fast_path();
    test_rd_zero();
    test_kill();
    test_start_while_busy();
    test_kill_start_idle();
    test_back_to_back();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative RV32M multiply/divide execution unit, placed directly downstream of the register file. It captures the two register read-port values (rs1/rs2) and the destination address on a start pulse. It computes one of the eight M-extension operations over multiple cycles, then presents the result and a one-cycle write strobe for the register file write port (WD3/AD3/WE3). Operations use shift-add (multiply) and restoring (divide) algorithms, one bit per cycle.

Parameters:
DATA_WIDTH, 32, operand/result width; iteration count equals DATA_WIDTH
ADDR_WIDTH, 5, register address width

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
kill  input  1  synchronous abort of the in-flight operation
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
rs1_val  input  DATA_WIDTH  operand A (register file RD1)
rs2_val  input  DATA_WIDTH  operand B (register file RD2)
rd_addr  input  ADDR_WIDTH  destination register
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
result  output  DATA_WIDTH  result; held until next completion
rd_out  output  ADDR_WIDTH  destination of the completed operation (to AD3)
wb_en  output  1  done && (rd_out != 0) (to WE3)

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy=0, done=0, wb_en=0, result=0, rd_out=0, counter=0. Reset mid-operation discards the operation with no done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE: on edge E0 with start=1:
  - latch funct3, rd_addr, operand magnitudes and sign flags (signed for MULH/DIV/REM, rs1 only for MULHSU, none for MULHU/DIVU/REMU/MUL treated as unsigned magnitude with sign fix).
  - Fast path (divide ops only) → DONE directly, result loaded at E0:
    - divisor==0: DIV/DIVU result all-ones; REM/REMU result = rs1_val.
    - DIV/REM with rs1=0x80000000 and rs2=all-ones: DIV result 0x80000000; REM result 0.
  - Otherwise → CALC with counter=0.
- CALC: one iteration per edge, counter increments. After DATA_WIDTH iterations (edges E1..E32) → FIX.
  - Multiply: 2*DATA_WIDTH-bit product accumulator.
  - Divide: DATA_WIDTH-bit quotient and remainder.
- FIX (one edge, E33):
  - Negate the product if operand signs differ.
  - Quotient is negative iff signs differ; remainder takes the dividend's sign.
  - Select the low word (MUL) or high word (MULH*); load result.
  - → DONE.
- DONE: done=1 for exactly one cycle; wb_en as defined; → IDLE on next edge.
- Latency: done is high in the cycle after E33 for normal ops, or the cycle after E0 for fast-path ops. Throughput: one op per 35 cycles max.
- start while busy (including the DONE cycle) is ignored; there is no queue.
- kill=1 in CALC or FIX → IDLE next edge: no done, result unchanged. kill in DONE has no effect (done still pulses). kill in IDLE has no effect and blocks nothing; start takes priority in IDLE.
- Simultaneous start and kill in IDLE: start accepted.
- Operand inputs may change after E0 without effect.
- All arithmetic is modulo 2^DATA_WIDTH per the RV32M definitions.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB; done exactly 34 cycles after start edge (cycle after E33); busy high 34 cycles.
- MULH 0x80000000*0x80000000 → 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000: done in cycle after start edge.
- rd_addr=0 with MUL 3*4 → done=1, result=12, wb_en=0. rd_addr=10 → wb_en=1, rd_out=10.
- kill at CALC iteration 10 → no done, busy drops next cycle, result keeps prior value. start during busy is ignored. rst_n low mid-CALC → all outputs 0 immediately.
